spi_master: RTL and testbench

SPI mode-0 master transmitter: takes bytes over a valid/ready handshake and serialises them MSB-first on SCLK/MOSI under an active-low chip select. It is the driving end for the on-chip SPI byte receiver, used for loopback self-test of the LED-data input path and for streaming frames to downstream SPI-fed devices. SCLK is derived from the system clock by a programmable divider. CS_n framing is controlled by a per-byte last flag.

---
 rtl/spi_master.sv | 221 ++++++++++++++++++++++
 tb/tb_spi_master.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_master.sv
// SPI mode-0 master transmitter.
// Accepts bytes over a valid/ready handshake and shifts them out MSB-first
// on SCLK/MOSI. CS_n framing follows the per-byte last flag: a frame stays
// selected across bytes until a byte marked last has been sent.
module spi_master #(
    parameter int CLK_DIV  = 4,
    parameter int CS_SETUP = 2,
    parameter int CS_HOLD  = 2,
    parameter int CS_IDLE  = 2
) (
    input  logic       clk_in,
    input  logic       rst_n_in,
    input  logic       byte_valid_in,
    input  logic [7:0] byte_data_in,
    input  logic       byte_last_in,
    output logic       byte_rdy_out,
    output logic       busy_out,
    output logic       spi_sclk_out,
    output logic       spi_mosi_out,
    output logic       spi_cs_n_out
);

    localparam int MAX_A     = (CLK_DIV > CS_SETUP) ? CLK_DIV : CS_SETUP;
    localparam int MAX_B     = (CS_HOLD > CS_IDLE) ? CS_HOLD : CS_IDLE;
    localparam int MAX_PHASE = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int PHASE_W   = $clog2(MAX_PHASE) + 1;

    localparam logic [PHASE_W-1:0] DIV_LAST   = PHASE_W'(CLK_DIV - 1);
    localparam logic [PHASE_W-1:0] SETUP_LAST = PHASE_W'(CS_SETUP - 1);
    localparam logic [PHASE_W-1:0] HOLD_LAST  = PHASE_W'(CS_HOLD - 1);
    localparam logic [PHASE_W-1:0] IDLE_LAST  = PHASE_W'(CS_IDLE - 1);
    localparam logic [PHASE_W-1:0] PHASE_ONE  = PHASE_W'(1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_LOW,
        ST_HIGH,
        ST_WAIT,
        ST_HOLD,
        ST_GAP
    } state_t;

    state_t               state_q, state_d;
    logic [PHASE_W-1:0]   phase_q, phase_d;
    logic [PHASE_W-1:0]   phase_limit;
    logic                 phase_end;
    logic [2:0]           bit_q, bit_d;
    logic [7:0]           shift_q, shift_d;
    logic                 last_q, last_d;
    logic                 cs_n_q, cs_n_d;
    logic                 sclk_q, sclk_d;
    logic                 mosi_q, mosi_d;
    logic                 rdy_q, rdy_d;
    logic                 busy_q, busy_d;
    logic                 accept;

    // A byte only transfers while we advertise ready, so data offered during
    // HOLD/GAP or mid-byte is ignored.
    assign accept = byte_valid_in & rdy_q;

    // Pick the terminal phase count for whichever timed state we are in.
    always_comb begin
        phase_limit = DIV_LAST;
        case (state_q)
            ST_SETUP: phase_limit = SETUP_LAST;
            ST_HOLD:  phase_limit = HOLD_LAST;
            ST_GAP:   phase_limit = IDLE_LAST;
            default:  phase_limit = DIV_LAST;
        endcase
    end

    assign phase_end = (phase_q == phase_limit);

    // Next-state and next-output decode; outputs are computed one cycle ahead
    // so every pin comes straight from a flop.
    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        last_d  = last_q;
        cs_n_d  = cs_n_q;
        sclk_d  = sclk_q;
        mosi_d  = mosi_q;
        rdy_d   = rdy_q;

        case (state_q)
            ST_IDLE: begin
                cs_n_d = 1'b1;
                sclk_d = 1'b0;
                rdy_d  = 1'b1;
                if (accept) begin
                    shift_d = byte_data_in;
                    last_d  = byte_last_in;
                    bit_d   = 3'd0;
                    phase_d = '0;
                    cs_n_d  = 1'b0;
                    mosi_d  = byte_data_in[7];
                    rdy_d   = 1'b0;
                    state_d = ST_SETUP;
                end
            end
            ST_SETUP: begin
                sclk_d = 1'b0;
                if (phase_end) begin
                    phase_d = '0;
                    state_d = ST_LOW;
                end else begin
                    phase_d = phase_q + PHASE_ONE;
                end
            end
            ST_LOW: begin
                if (phase_end) begin
                    phase_d = '0;
                    sclk_d  = 1'b1;
                    state_d = ST_HIGH;
                end else begin
                    phase_d = phase_q + PHASE_ONE;
                end
            end
            ST_HIGH: begin
                if (phase_end) begin
                    phase_d = '0;
                    sclk_d  = 1'b0;
                    if (bit_q != 3'd7) begin
                        bit_d   = bit_q + 3'd1;
                        shift_d = {shift_q[6:0], 1'b0};
                        mosi_d  = shift_q[6];
                        state_d = ST_LOW;
                    end else if (last_q) begin
                        state_d = ST_HOLD;
                    end else begin
                        rdy_d   = 1'b1;
                        state_d = ST_WAIT;
                    end
                end else begin
                    phase_d = phase_q + PHASE_ONE;
                end
            end
            ST_WAIT: begin
                sclk_d = 1'b0;
                rdy_d  = 1'b1;
                if (accept) begin
                    shift_d = byte_data_in;
                    last_d  = byte_last_in;
                    bit_d   = 3'd0;
                    phase_d = '0;
                    mosi_d  = byte_data_in[7];
                    rdy_d   = 1'b0;
                    state_d = ST_LOW;
                end
            end
            ST_HOLD: begin
                sclk_d = 1'b0;
                if (phase_end) begin
                    phase_d = '0;
                    cs_n_d  = 1'b1;
                    mosi_d  = 1'b0;
                    state_d = ST_GAP;
                end else begin
                    phase_d = phase_q + PHASE_ONE;
                end
            end
            ST_GAP: begin
                rdy_d = 1'b0;
                if (phase_end) begin
                    phase_d = '0;
                    rdy_d   = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    phase_d = phase_q + PHASE_ONE;
                end
            end
            default: begin
                phase_d = '0;
                cs_n_d  = 1'b1;
                sclk_d  = 1'b0;
                mosi_d  = 1'b0;
                rdy_d   = 1'b1;
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // State, datapath and output flops; reset drops any partial byte at once.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q <= ST_IDLE;
            phase_q <= '0;
            bit_q   <= 3'd0;
            shift_q <= 8'd0;
            last_q  <= 1'b0;
            cs_n_q  <= 1'b1;
            sclk_q  <= 1'b0;
            mosi_q  <= 1'b0;
            rdy_q   <= 1'b1;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            last_q  <= last_d;
            cs_n_q  <= cs_n_d;
            sclk_q  <= sclk_d;
            mosi_q  <= mosi_d;
            rdy_q   <= rdy_d;
            busy_q  <= busy_d;
        end
    end

    assign byte_rdy_out = rdy_q;
    assign busy_out     = busy_q;
    assign spi_sclk_out = sclk_q;
    assign spi_mosi_out = mosi_q;
    assign spi_cs_n_out = cs_n_q;

endmodule

// File: tb/tb_spi_master.sv
// Testbench for spi_master: stimulus pushes expected bytes into a queue,
// a receiver monitor deserialises MOSI on SCLK rises and pops/compares.
module tb_spi_master;

    localparam int CLK_DIV  = 2;
    localparam int CS_SETUP = 1;
    localparam int CS_HOLD  = 2;
    localparam int CS_IDLE  = 2;
    localparam int LIMIT    = 3000;

    logic       clk_in = 1'b0;
    logic       rst_n_in = 1'b0;
    logic       byte_valid_in = 1'b0;
    logic [7:0] byte_data_in = 8'd0;
    logic       byte_last_in = 1'b0;
    logic       byte_rdy_out;
    logic       busy_out;
    logic       spi_sclk_out;
    logic       spi_mosi_out;
    logic       spi_cs_n_out;

    int n_compared = 0;
    int n_mismatched = 0;
    int cyc = 0;

    logic [7:0] exp_q[$];

    int accept_cyc = -1;
    int cs_fall_cyc = 0;
    int cs_rise_cyc = 0;
    int cs_high_len = 0;
    int rdy_rise_cyc = 0;
    int first_rise_cyc = 0;
    int last_rise_cyc = 0;
    int last_fall_cyc = 0;
    int last_mosi_cyc = 0;
    int rises = 0;
    int cs_falls = 0;
    int rdy_pulses = 0;
    int rx_cnt = 0;
    bit first_rise_pending = 1'b0;
    logic [7:0] rx_shift = 8'd0;
    logic prev_cs_n = 1'b1;
    logic prev_sclk = 1'b0;
    logic prev_mosi = 1'b0;
    logic prev_rdy = 1'b1;

    spi_master #(
        .CLK_DIV(CLK_DIV),
        .CS_SETUP(CS_SETUP),
        .CS_HOLD(CS_HOLD),
        .CS_IDLE(CS_IDLE)
    ) dut (
        .clk_in(clk_in),
        .rst_n_in(rst_n_in),
        .byte_valid_in(byte_valid_in),
        .byte_data_in(byte_data_in),
        .byte_last_in(byte_last_in),
        .byte_rdy_out(byte_rdy_out),
        .busy_out(busy_out),
        .spi_sclk_out(spi_sclk_out),
        .spi_mosi_out(spi_mosi_out),
        .spi_cs_n_out(spi_cs_n_out)
    );

    always #5 clk_in = ~clk_in;

    always @(posedge clk_in) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input int actual, input int expected);
        n_compared++;
        if (actual !== expected) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got %0d expected %0d (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    // Offer a byte (caller sits just after a negedge) and return after the
    // accepting edge; valid is left high so streams can be chained.
    task automatic applyStimulus(input logic [7:0] data, input logic last, input bit expect_rx);
        int i;
        byte_data_in  = data;
        byte_last_in  = last;
        byte_valid_in = 1'b1;
        i = 0;
        while (!byte_rdy_out && i < LIMIT) begin
            @(negedge clk_in);
            i++;
        end
        if (!byte_rdy_out) begin
            checkOutput("accept_timeout", 0, 1);
            return;
        end
        accept_cyc = cyc + 1;
        if (expect_rx) exp_q.push_back(data);
        @(negedge clk_in);
    endtask

    task automatic idleInputs();
        byte_valid_in = 1'b0;
        byte_last_in  = 1'b0;
        byte_data_in  = 8'd0;
    endtask

    task automatic waitFrameEnd();
        int i;
        i = 0;
        while (!(spi_cs_n_out && !busy_out && byte_rdy_out) && i < LIMIT) begin
            @(negedge clk_in);
            i++;
        end
        if (!(spi_cs_n_out && !busy_out && byte_rdy_out)) checkOutput("frame_end_timeout", 0, 1);
        @(negedge clk_in);
    endtask

    // Receiver model and protocol monitor, sampled on the falling clock edge.
    always @(negedge clk_in) begin
        if (!rst_n_in) begin
            rx_cnt = 0;
        end else begin
            if (!spi_cs_n_out && prev_cs_n) begin
                checkOutput("cs_fall_at_accept", cyc, accept_cyc);
                cs_high_len = cyc - cs_rise_cyc;
                cs_fall_cyc = cyc;
                cs_falls++;
                rdy_pulses = 0;
                rx_cnt = 0;
                first_rise_pending = 1'b1;
            end
            if (spi_cs_n_out && !prev_cs_n) begin
                checkOutput("cs_rise_sclk_low", int'(spi_sclk_out), 0);
                checkOutput("cs_hold", cyc - last_fall_cyc, CS_HOLD);
                cs_rise_cyc = cyc;
            end
            if (spi_cs_n_out && busy_out) checkOutput("rdy_low_in_gap", int'(byte_rdy_out), 0);
            if (byte_rdy_out && !prev_rdy) begin
                if (!spi_cs_n_out) rdy_pulses++;
                else rdy_rise_cyc = cyc;
            end
            if (spi_mosi_out != prev_mosi) begin
                checkOutput("mosi_change_sclk_low", int'(spi_sclk_out), 0);
                last_mosi_cyc = cyc;
            end
            if (spi_sclk_out && !prev_sclk) begin
                checkOutput("sclk_rise_cs_low", int'(spi_cs_n_out), 0);
                checkOutput("mosi_setup", int'(cyc - last_mosi_cyc >= CLK_DIV), 1);
                if (first_rise_pending) begin
                    first_rise_cyc = cyc;
                    first_rise_pending = 1'b0;
                end else if (rx_cnt != 0) begin
                    checkOutput("bit_spacing", cyc - last_rise_cyc, 2 * CLK_DIV);
                end
                last_rise_cyc = cyc;
                rises++;
                rx_shift = {rx_shift[6:0], spi_mosi_out};
                rx_cnt++;
                if (rx_cnt == 8) begin
                    rx_cnt = 0;
                    if (exp_q.size() == 0) begin
                        n_compared++;
                        n_mismatched++;
                        $display("[TB] FAIL rx_unexpected: got 0x%02h with nothing expected", rx_shift);
                    end else begin
                        checkOutput("rx_byte", int'(rx_shift), int'(exp_q.pop_front()));
                    end
                end
            end
            if (!spi_sclk_out && prev_sclk) last_fall_cyc = cyc;
        end
        prev_cs_n = spi_cs_n_out;
        prev_sclk = spi_sclk_out;
        prev_mosi = spi_mosi_out;
        prev_rdy  = byte_rdy_out;
    end

    // Directed scenarios.
    initial begin
        int r0;
        int f0;
        int a2;
        int r1;
        int i;

        $display("[TB] reset with valid high");
        byte_valid_in = 1'b1;
        byte_data_in  = 8'hFF;
        byte_last_in  = 1'b1;
        repeat (3) @(negedge clk_in);
        checkOutput("rst_cs_n", int'(spi_cs_n_out), 1);
        checkOutput("rst_sclk", int'(spi_sclk_out), 0);
        checkOutput("rst_mosi", int'(spi_mosi_out), 0);
        checkOutput("rst_rdy", int'(byte_rdy_out), 1);
        checkOutput("rst_busy", int'(busy_out), 0);
        idleInputs();
        rst_n_in = 1'b1;
        repeat (3) @(negedge clk_in);
        checkOutput("post_rst_busy", int'(busy_out), 0);
        checkOutput("post_rst_cs_n", int'(spi_cs_n_out), 1);

        $display("[TB] single byte 0xA5");
        r0 = rises;
        applyStimulus(8'hA5, 1'b1, 1'b1);
        idleInputs();
        checkOutput("single_cs_low", int'(spi_cs_n_out), 0);
        checkOutput("single_busy", int'(busy_out), 1);
        waitFrameEnd();
        checkOutput("single_rises", rises - r0, 8);
        checkOutput("single_first_rise", first_rise_cyc - cs_fall_cyc, CS_SETUP + CLK_DIV);
        checkOutput("single_rdy_after_gap", rdy_rise_cyc - cs_rise_cyc, CS_IDLE);

        $display("[TB] back-to-back stream");
        r0 = rises;
        f0 = cs_falls;
        applyStimulus(8'h00, 1'b0, 1'b1);
        applyStimulus(8'hFF, 1'b0, 1'b1);
        applyStimulus(8'h3C, 1'b1, 1'b1);
        idleInputs();
        waitFrameEnd();
        checkOutput("stream_rises", rises - r0, 24);
        checkOutput("stream_cs_windows", cs_falls - f0, 1);
        checkOutput("stream_rdy_pulses", rdy_pulses, 2);

        $display("[TB] stalled stream");
        f0 = cs_falls;
        applyStimulus(8'h81, 1'b0, 1'b1);
        idleInputs();
        repeat (50) @(negedge clk_in);
        checkOutput("stall_cs_low", int'(spi_cs_n_out), 0);
        checkOutput("stall_sclk_low", int'(spi_sclk_out), 0);
        checkOutput("stall_rdy", int'(byte_rdy_out), 1);
        checkOutput("stall_busy", int'(busy_out), 1);
        applyStimulus(8'h7E, 1'b1, 1'b1);
        idleInputs();
        waitFrameEnd();
        checkOutput("stall_cs_windows", cs_falls - f0, 1);

        $display("[TB] back-to-back frames");
        f0 = cs_falls;
        applyStimulus(8'h11, 1'b1, 1'b1);
        applyStimulus(8'h22, 1'b1, 1'b1);
        a2 = accept_cyc;
        r1 = cs_rise_cyc;
        idleInputs();
        waitFrameEnd();
        checkOutput("frames_cs_windows", cs_falls - f0, 2);
        checkOutput("frames_second_accept", a2 - r1, CS_IDLE + 1);
        checkOutput("frames_cs_high_len", cs_high_len, CS_IDLE + 1);

        $display("[TB] mid-byte reset");
        r0 = rises;
        applyStimulus(8'hC3, 1'b1, 1'b0);
        idleInputs();
        i = 0;
        while (rises < r0 + 3 && i < LIMIT) begin
            @(negedge clk_in);
            i++;
        end
        checkOutput("midrst_third_rise", int'(rises >= r0 + 3), 1);
        #1;
        rst_n_in = 1'b0;
        #1;
        checkOutput("midrst_cs_n", int'(spi_cs_n_out), 1);
        checkOutput("midrst_sclk", int'(spi_sclk_out), 0);
        checkOutput("midrst_mosi", int'(spi_mosi_out), 0);
        checkOutput("midrst_busy", int'(busy_out), 0);
        checkOutput("midrst_rdy", int'(byte_rdy_out), 1);
        repeat (2) @(negedge clk_in);
        rst_n_in = 1'b1;
        @(negedge clk_in);
        r0 = rises;
        applyStimulus(8'h5A, 1'b1, 1'b1);
        idleInputs();
        waitFrameEnd();
        checkOutput("after_rst_rises", rises - r0, 8);

        repeat (4) @(negedge clk_in);
        checkOutput("exp_queue_empty", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
